// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and default widths for the memory port arbiter.
//   arb_state_e : FSM states (IDLE, REQ, WAIT, RESP)
//   owner_e     : which requester owns the outstanding transaction
//   DEF_*       : default parameter values for the arbiter
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_PTW  = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_timeout_ctr.sv
// mem_arb_timeout_ctr -- counts consecutive cycles spent waiting for a memory
// response and flags the last one. Only instantiated when MEMARB_TIMEOUT_EN
// is defined.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en_i        : high while the arbiter is in WAIT; low clears the count
//   expired_o   : high during the TIMEOUT_CYCLES-th consecutive enabled cycle
module mem_arb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count resets whenever WAIT is left, so it never needs to saturate.
  assign cnt_d     = en_i ? cnt_q + 1'b1 : '0;
  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mem_arb_timeout_ctr

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter -- shares one memory port between the page-table walker
// (fixed high priority) and the translated data path. One transaction is
// outstanding at a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//   ptw_req/ptw_addr -> ptw_resp/ptw_data   : page-walk reads (level request)
//   dreq_* (valid/ready) -> dresp_*         : data reads/writes
//   mem_req_* (valid/ready), mem_resp_*     : downstream memory port
//   busy                                    : high whenever not IDLE
// Optional: define MEMARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles
// (data owner sees dresp_err=1; PTW owner sees ptw_data=0).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ptw_req,
  input  logic [ADDR_WIDTH-1:0]   ptw_addr,
  output logic                    ptw_resp,
  output logic [DATA_WIDTH-1:0]   ptw_data,
  input  logic                    dreq_valid,
  output logic                    dreq_ready,
  input  logic                    dreq_we,
  input  logic [ADDR_WIDTH-1:0]   dreq_addr,
  input  logic [DATA_WIDTH-1:0]   dreq_wdata,
  input  logic [DATA_WIDTH/8-1:0] dreq_be,
  output logic                    dresp_valid,
  output logic [DATA_WIDTH-1:0]   dresp_rdata,
  output logic                    dresp_err,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_be,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    busy
);

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] be_q, be_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

`ifdef MEMARB_TIMEOUT_EN
  logic err_q, err_d;
  logic timeout_hit;

  mem_arb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (state_q == ST_WAIT),
    .expired_o(timeout_hit)
  );

  assign dresp_err = (state_q == ST_RESP) && (owner_q == OWN_DATA) && err_q;
`else
  // Parameter kept for interface compatibility with the timeout build.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign dresp_err             = 1'b0;
`endif

  // Combinational handshake: data is held off whenever a walk is pending.
  assign dreq_ready    = (state_q == ST_IDLE) && !ptw_req;
  assign busy          = (state_q != ST_IDLE);
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_be    = be_q;
  assign ptw_resp      = (state_q == ST_RESP) && (owner_q == OWN_PTW);
  assign dresp_valid   = (state_q == ST_RESP) && (owner_q == OWN_DATA);
  assign ptw_data      = rdata_q;
  assign dresp_rdata   = rdata_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
`ifdef MEMARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (ptw_req) begin
          // Walks are always reads of a full word.
          owner_d = OWN_PTW;
          we_d    = 1'b0;
          addr_d  = ptw_addr;
          wdata_d = '0;
          be_d    = '1;
          rdata_d = '0;
          state_d = ST_REQ;
        end else if (dreq_valid) begin
          owner_d = OWN_DATA;
          we_d    = dreq_we;
          addr_d  = dreq_addr;
          wdata_d = dreq_wdata;
          be_d    = dreq_be;
          rdata_d = '0;
          state_d = ST_REQ;
        end
`ifdef MEMARB_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          // Writes report zero read data regardless of what memory returns.
          rdata_d = we_q ? '0 : mem_resp_data;
          state_d = ST_RESP;
        end
`ifdef MEMARB_TIMEOUT_EN
        else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = (owner_q == OWN_DATA);
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_PTW;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
`ifdef MEMARB_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
`ifdef MEMARB_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter -- directed self-checking bench for mem_port_arbiter.
// Inputs change on the falling edge; outputs are checked on the falling edge
// (registered values) or 1 time unit after an input change (dreq_ready).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ptw_req;
  logic [AW-1:0] ptw_addr;
  logic          ptw_resp;
  logic [DW-1:0] ptw_data;
  logic          dreq_valid;
  logic          dreq_ready;
  logic          dreq_we;
  logic [AW-1:0] dreq_addr;
  logic [DW-1:0] dreq_wdata;
  logic [3:0]    dreq_be;
  logic          dresp_valid;
  logic [DW-1:0] dresp_rdata;
  logic          dresp_err;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [3:0]    mem_req_be;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          busy;

  int vectors    = 0;
  int miscompares = 0;
  int ptw_cnt    = 0;
  int dresp_cnt  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ptw_req       (ptw_req),
    .ptw_addr      (ptw_addr),
    .ptw_resp      (ptw_resp),
    .ptw_data      (ptw_data),
    .dreq_valid    (dreq_valid),
    .dreq_ready    (dreq_ready),
    .dreq_we       (dreq_we),
    .dreq_addr     (dreq_addr),
    .dreq_wdata    (dreq_wdata),
    .dreq_be       (dreq_be),
    .dresp_valid   (dresp_valid),
    .dresp_rdata   (dresp_rdata),
    .dresp_err     (dresp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_be    (mem_req_be),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .busy          (busy)
  );

  // Response pulse counters, sampled just before each rising edge.
  always @(posedge clk) begin
    if (ptw_resp)    ptw_cnt++;
    if (dresp_valid) dresp_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a data request for one cycle (caller guarantees IDLE, no walk).
  task automatic issue_data(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [3:0] be);
    dreq_valid = 1'b1; dreq_we = we; dreq_addr = addr; dreq_wdata = wdata; dreq_be = be;
    #1 check("issue_dready", dreq_ready, 1);
    tick();
    dreq_valid = 1'b0; dreq_we = 1'b0; dreq_addr = '0; dreq_wdata = '0; dreq_be = '0;
  endtask

  task automatic accept();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [DW-1:0] data);
    mem_resp_valid = 1'b1; mem_resp_data = data;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  initial begin
    int p0, d0, n;
    rst_n = 1'b0; ptw_req = 0; ptw_addr = '0; dreq_valid = 0; dreq_we = 0;
    dreq_addr = '0; dreq_wdata = '0; dreq_be = '0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
    repeat (2) tick();

    // Reset state
    check("rst_busy",     busy, 0);
    check("rst_mvalid",   mem_req_valid, 0);
    check("rst_ptw_resp", ptw_resp, 0);
    check("rst_dresp",    dresp_valid, 0);
    check("rst_err",      dresp_err, 0);
    check("rst_maddr",    mem_req_addr, 0);
    check("rst_dready",   dreq_ready, 1);
    rst_n = 1'b1;
    tick();

    // PTW read of 0x1000 returning 0x2000_00CF
    p0 = ptw_cnt; d0 = dresp_cnt;
    ptw_req = 1'b1; ptw_addr = 32'h0000_1000;
    #1 check("ptw_dready_low", dreq_ready, 0);
    tick();
    check("ptw_mvalid", mem_req_valid, 1);
    check("ptw_maddr",  mem_req_addr, 32'h0000_1000);
    check("ptw_mwe",    mem_req_we, 0);
    check("ptw_mbe",    mem_req_be, 4'hF);
    check("ptw_mwdata", mem_req_wdata, 0);
    accept();
    check("ptw_wait_mvalid", mem_req_valid, 0);
    check("ptw_wait_busy",   busy, 1);
    respond(32'h2000_00CF);
    check("ptw_resp",       ptw_resp, 1);
    check("ptw_data",       ptw_data, 32'h2000_00CF);
    check("ptw_no_dresp",   dresp_valid, 0);
    ptw_req = 1'b0;
    tick();
    check("ptw_resp_end",   ptw_resp, 0);
    check("ptw_idle",       busy, 0);
    check("ptw_pulses",     ptw_cnt - p0, 1);
    check("ptw_dpulses",    dresp_cnt - d0, 0);

    // Data write held through 3 cycles of mem_req_ready=0
    p0 = ptw_cnt; d0 = dresp_cnt;
    issue_data(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      check("wr_mvalid", mem_req_valid, 1);
      check("wr_mwe",    mem_req_we, 1);
      check("wr_maddr",  mem_req_addr, 32'h8000_0010);
      check("wr_mwdata", mem_req_wdata, 32'hDEAD_BEEF);
      check("wr_mbe",    mem_req_be, 4'hF);
      tick();
    end
    check("wr_mvalid_last", mem_req_valid, 1);
    accept();
    respond(32'h1234_5678);
    check("wr_dresp",   dresp_valid, 1);
    check("wr_rdata0",  dresp_rdata, 0);
    check("wr_err",     dresp_err, 0);
    check("wr_no_ptw",  ptw_resp, 0);
    tick();
    check("wr_pulses",  dresp_cnt - d0, 1);
    check("wr_ppulses", ptw_cnt - p0, 0);

    // Simultaneous PTW and data requests: PTW first
    p0 = ptw_cnt; d0 = dresp_cnt;
    ptw_req = 1'b1; ptw_addr = 32'h0000_2000;
    dreq_valid = 1'b1; dreq_we = 1'b0; dreq_addr = 32'h8000_0020; dreq_be = 4'hF;
    #1 check("both_dready", dreq_ready, 0);
    tick();
    check("both_first_addr", mem_req_addr, 32'h0000_2000);
    check("both_first_we",   mem_req_we, 0);
    check("both_dready_req", dreq_ready, 0);
    accept();
    check("both_dready_wait", dreq_ready, 0);
    respond(32'hAAAA_5555);
    check("both_ptw_resp", ptw_resp, 1);
    check("both_ptw_data", ptw_data, 32'hAAAA_5555);
    check("both_dready_resp", dreq_ready, 0);
    ptw_req = 1'b0;
    tick();
    check("both_dready_idle", dreq_ready, 1);
    tick();
    dreq_valid = 1'b0; dreq_addr = '0; dreq_be = '0;
    check("both_second_valid", mem_req_valid, 1);
    check("both_second_addr",  mem_req_addr, 32'h8000_0020);
    check("both_second_we",    mem_req_we, 0);
    accept();
    respond(32'h0BAD_F00D);
    check("both_dresp",  dresp_valid, 1);
    check("both_rdata",  dresp_rdata, 32'h0BAD_F00D);
    tick();
    check("both_ppulses", ptw_cnt - p0, 1);
    check("both_dpulses", dresp_cnt - d0, 1);

    // Reset while in WAIT, then a late memory response
    p0 = ptw_cnt; d0 = dresp_cnt;
    issue_data(1'b0, 32'h8000_0040, '0, 4'hF);
    accept();
    check("rw_in_wait", busy, 1);
    rst_n = 1'b0;
    #1 check("rw_async_idle", busy, 0);
    tick();
    rst_n = 1'b1;
    respond(32'hFEED_FACE);
    check("rw_no_dresp", dresp_valid, 0);
    check("rw_idle",     busy, 0);
    check("rw_mvalid",   mem_req_valid, 0);
    tick();
    check("rw_ppulses",  ptw_cnt - p0, 0);
    check("rw_dpulses",  dresp_cnt - d0, 0);

`ifdef MEMARB_TIMEOUT_EN
    // Data read with no response: error pulse after 8 WAIT cycles
    d0 = dresp_cnt;
    issue_data(1'b0, 32'h8000_0080, '0, 4'hF);
    accept();
    n = 0;
    while (!dresp_valid && n < 20) begin
      n++;
      tick();
    end
    check("to_wait_cycles", n, 8);
    check("to_dresp", dresp_valid, 1);
    check("to_err",   dresp_err, 1);
    check("to_rdata", dresp_rdata, 0);
    tick();
    check("to_pulses", dresp_cnt - d0, 1);
    check("to_idle",   busy, 0);
`else
    // Without the timeout, WAIT holds until memory answers
    d0 = dresp_cnt;
    issue_data(1'b0, 32'h8000_0080, '0, 4'hF);
    accept();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy && !dresp_valid) n++;
      tick();
    end
    check("nt_wait_held", n, 20);
    respond(32'h5A5A_0001);
    check("nt_dresp", dresp_valid, 1);
    check("nt_err",   dresp_err, 0);
    check("nt_rdata", dresp_rdata, 32'h5A5A_0001);
    tick();
    check("nt_pulses", dresp_cnt - d0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_port_arbiter
